stopwatch_display: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 38 +++
 rtl/stopwatch_display_seg7_decoder.sv | 38 +++
 rtl/stopwatch_display.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_display.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display slice.
// Holds the active-low 7-segment codes ({g,f,e,d,c,b,a}), the scan digit
// positions, the field range limits, the captured-input record and a
// binary-to-two-digit split helper.
package stopwatch_pkg;

  // Active-low digit patterns, index = decimal digit
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Scan positions, 0 = rightmost digit
  localparam logic [1:0] IDX_SEC_U = 2'd0;
  localparam logic [1:0] IDX_SEC_T = 2'd1;
  localparam logic [1:0] IDX_MIN_U = 2'd2;
  localparam logic [1:0] IDX_MIN_T = 2'd3;

  localparam logic [6:0] MAX_MIN = 7'd99;
  localparam logic [5:0] MAX_SEC = 6'd59;

  // Everything captured from the counter domain, moved as one word
  typedef struct packed {
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       adj;
    logic       sel;
  } ctrl_t;

  // Split a 0..99 value into {tens, units}; larger values are shown as
  // dashes by the caller, so their digits are never displayed.
  function automatic logic [7:0] split_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decoder.sv
// Combinational 7-segment decoder.
// Ports: value - 4-bit digit (0..9); dash - show a centre bar;
//        blank - all segments off (wins over dash); seg - {g..a}, active-low.
// Values above 9 fall back to blank.
module stopwatch_display_seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern selection: blank, then dash, then digit lookup
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (value)
        4'd0:    seg = SEG_DIGIT[0];
        4'd1:    seg = SEG_DIGIT[1];
        4'd2:    seg = SEG_DIGIT[2];
        4'd3:    seg = SEG_DIGIT[3];
        4'd4:    seg = SEG_DIGIT[4];
        4'd5:    seg = SEG_DIGIT[5];
        4'd6:    seg = SEG_DIGIT[6];
        4'd7:    seg = SEG_DIGIT[7];
        4'd8:    seg = SEG_DIGIT[8];
        4'd9:    seg = SEG_DIGIT[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch 4-digit multiplexed display driver (common anode, active-low).
// Ports: clock, rst (async, active-high); minutes[6:0], seconds[5:0], adj, sel
//        from the slow counter domain; seg[6:0] {g..a}, an[3:0] (an[0] =
//        rightmost), dp - all active-low and registered.
// Inputs pass two sample stages; the shadow copy only takes a value seen
// unchanged in both stages, so a single-cycle glitch is never displayed.
// Digit order: seconds units, seconds tens, minutes units, minutes tens.
// In adjust mode the selected field is blanked while blink_phase is 1.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [6:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_TC  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_DIV - 1);

  ctrl_t              in_s;
  ctrl_t              s1_r;
  ctrl_t              s2_r;
  ctrl_t              shadow_r;
  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [1:0]         idx_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_phase_r;
  logic [6:0]         seg_r;
  logic [3:0]         an_r;
  logic               dp_r;

  logic [7:0]         sec_bcd_s;
  logic [7:0]         min_bcd_s;
  logic               sec_oor_s;
  logic               min_oor_s;
  logic [3:0]         digit_s;
  logic               dash_s;
  logic               blank_s;
  logic [6:0]         seg_next_s;
  logic [3:0]         an_next_s;
  logic               dp_next_s;

  assign in_s = {minutes, seconds, adj, sel};

  // Two-stage sampling plus stability-qualified shadow load
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s1_r     <= '0;
      s2_r     <= '0;
      shadow_r <= '0;
    end else begin
      s1_r <= in_s;
      s2_r <= s1_r;
      if (s1_r == s2_r) begin
        shadow_r <= s2_r;
      end
    end
  end

  // Scan prescaler and digit index rotation
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      scan_cnt_r <= '0;
      idx_r      <= 2'd0;
    end else if (scan_cnt_r == SCAN_TC) begin
      scan_cnt_r <= '0;
      idx_r      <= idx_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + 1'b1;
    end
  end

  // Blink prescaler and phase toggle
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (blink_cnt_r == BLINK_TC) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 1'b1;
    end
  end

  assign sec_bcd_s = split_bcd({1'b0, shadow_r.seconds});
  assign min_bcd_s = split_bcd(shadow_r.minutes);
  assign sec_oor_s = (shadow_r.seconds > MAX_SEC);
  assign min_oor_s = (shadow_r.minutes > MAX_MIN);

  // Digit value and dash flag for the current scan position
  always_comb begin
    digit_s = 4'd0;
    dash_s  = 1'b0;
    case (idx_r)
      IDX_SEC_U: begin digit_s = sec_bcd_s[3:0]; dash_s = sec_oor_s; end
      IDX_SEC_T: begin digit_s = sec_bcd_s[7:4]; dash_s = sec_oor_s; end
      IDX_MIN_U: begin digit_s = min_bcd_s[3:0]; dash_s = min_oor_s; end
      IDX_MIN_T: begin digit_s = min_bcd_s[7:4]; dash_s = min_oor_s; end
      default:   begin digit_s = 4'd0;           dash_s = 1'b1;      end
    endcase
  end

  // Blanking of the field under adjustment during the blink-off phase
  always_comb begin
    blank_s = 1'b0;
    if (shadow_r.adj && blink_phase_r) begin
      if (shadow_r.sel) begin
        blank_s = (idx_r == IDX_SEC_U) || (idx_r == IDX_SEC_T);
      end else begin
        blank_s = (idx_r == IDX_MIN_U) || (idx_r == IDX_MIN_T);
      end
    end else begin
      blank_s = 1'b0;
    end
  end

  stopwatch_display_seg7_decoder u_dec (
    .value (digit_s),
    .dash  (dash_s),
    .blank (blank_s),
    .seg   (seg_next_s)
  );

  // Anode and separator for the current slot
  always_comb begin
    an_next_s = 4'b1111;
    dp_next_s = 1'b1;
    if (blank_s) begin
      an_next_s = 4'b1111;
      dp_next_s = 1'b1;
    end else begin
      an_next_s = ~(4'b0001 << idx_r);
      dp_next_s = (idx_r == IDX_MIN_U) ? 1'b0 : 1'b1;
    end
  end

  // Registered display outputs, reloaded every cycle
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      seg_r <= SEG_BLANK;
      an_r  <= 4'b1111;
      dp_r  <= 1'b1;
    end else begin
      seg_r <= seg_next_s;
      an_r  <= an_next_s;
      dp_r  <= dp_next_s;
    end
  end

  assign seg = seg_r;
  assign an  = an_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed self-checking bench for stopwatch_display with CLK_HZ=1000,
// SCAN_HZ=100 (10 cycles per digit), BLINK_HZ=5 (100-cycle blink halves).
// kcnt counts rising edges since reset release; the output sampled after
// edge k shows digit floor((k-1)/10)%4 with blink phase floor((k-1)/100)%2.
module tb_stopwatch_display;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic [6:0] minutes = 7'd0;
  logic [5:0] seconds = 6'd0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int kcnt   = 0;

  stopwatch_display #(
    .CLK_HZ   (1000),
    .SCAN_HZ  (100),
    .BLINK_HZ (5)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .minutes (minutes),
    .seconds (seconds),
    .adj     (adj),
    .sel     (sel),
    .seg     (seg),
    .an      (an),
    .dp      (dp)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    kcnt++;
  endtask

  task automatic tick_to(input int k);
    while (kcnt < k) tick();
  endtask

  task automatic apply_reset(input logic [6:0] m, input logic [5:0] s,
                             input logic a, input logic sl);
    minutes = m; seconds = s; adj = a; sel = sl;
    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    kcnt = 0;
  endtask

  task automatic test_reset();
    minutes = 7'd42; seconds = 6'd7; adj = 1'b0; sel = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (seg !== 7'h7F || an !== 4'b1111 || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: seg=%b an=%b dp=%b expected 1111111 1111 1", seg, an, dp);
    end
    rst = 1'b0;
    kcnt = 0;
    tick();
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL first_cycle: an=%b seg=%b expected 1110 1000000", an, seg);
    end
    tick_to(10);
    checks++;
    if (an !== 4'b1110) begin
      errors++; $display("FAIL slot0_end: an=%b expected 1110", an);
    end
    tick_to(11);
    checks++;
    if (an !== 4'b1101) begin
      errors++; $display("FAIL slot1_start: an=%b expected 1101", an);
    end
    tick_to(21);
    checks++;
    if (an !== 4'b1011) begin
      errors++; $display("FAIL slot2_start: an=%b expected 1011", an);
    end
  endtask

  task automatic test_rotation();
    int         k_v  [5] = '{5, 15, 25, 35, 45};
    logic [3:0] an_v [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] seg_v[5] = '{7'b1111000, 7'b1000000, 7'b0100100, 7'b0011001, 7'b1111000};
    logic       dp_v [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    apply_reset(7'd42, 6'd7, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick_to(k_v[i]);
      checks++;
      if (an !== an_v[i] || seg !== seg_v[i] || dp !== dp_v[i]) begin
        errors++;
        $display("FAIL rotation k=%0d: an=%b seg=%b dp=%b expected %b %b %b",
                 k_v[i], an, seg, dp, an_v[i], seg_v[i], dp_v[i]);
      end
    end
  endtask

  task automatic test_blink_minutes();
    int min_low = 0;
    int blanked = 0;
    int d0_on   = 0;
    int         k_v [3] = '{205, 225, 235};
    logic [3:0] an_v[3] = '{4'b1110, 4'b1011, 4'b0111};
    apply_reset(7'd42, 6'd7, 1'b1, 1'b0);
    tick_to(95);
    checks++;
    if (an !== 4'b1101) begin
      errors++; $display("FAIL blink_min_before: an=%b expected 1101", an);
    end
    tick_to(100);
    for (int k = 101; k <= 200; k++) begin
      tick();
      if (an[3] == 1'b0 || an[2] == 1'b0) min_low++;
      if (an == 4'b1111) blanked++;
      if (an[0] == 1'b0) d0_on++;
    end
    checks++;
    if (min_low !== 0) begin
      errors++; $display("FAIL blink_min_never_low: count=%0d expected 0", min_low);
    end
    checks++;
    if (blanked !== 60) begin
      errors++; $display("FAIL blink_min_blanked: count=%0d expected 60", blanked);
    end
    checks++;
    if (d0_on !== 20) begin
      errors++; $display("FAIL blink_min_sec_scan: count=%0d expected 20", d0_on);
    end
    for (int i = 0; i < 3; i++) begin
      tick_to(k_v[i]);
      checks++;
      if (an !== an_v[i]) begin
        errors++;
        $display("FAIL blink_min_on k=%0d: an=%b expected %b", k_v[i], an, an_v[i]);
      end
    end
  endtask

  task automatic test_blink_seconds();
    int blanked = 0;
    int d3_on   = 0;
    int         k_v  [5] = '{205, 215, 225, 235, 325};
    logic [3:0] an_v [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111};
    logic [6:0] seg_v[5] = '{7'b0010000, 7'b0010010, 7'b0100100, 7'b0011001, 7'h7F};
    apply_reset(7'd42, 6'd59, 1'b1, 1'b1);
    tick_to(100);
    for (int k = 101; k <= 200; k++) begin
      tick();
      if (an == 4'b1111) blanked++;
      if (an[3] == 1'b0) d3_on++;
      if (k == 105) begin
        checks++;
        if (an !== 4'b1011 || seg !== 7'b0100100 || dp !== 1'b0) begin
          errors++;
          $display("FAIL blink_sec_min_shown: an=%b seg=%b dp=%b expected 1011 0100100 0", an, seg, dp);
        end
      end
    end
    checks++;
    if (blanked !== 40) begin
      errors++; $display("FAIL blink_sec_blanked: count=%0d expected 40", blanked);
    end
    checks++;
    if (d3_on !== 30) begin
      errors++; $display("FAIL blink_sec_min_scan: count=%0d expected 30", d3_on);
    end
    for (int i = 0; i < 5; i++) begin
      tick_to(k_v[i]);
      checks++;
      if (an !== an_v[i] || seg !== seg_v[i]) begin
        errors++;
        $display("FAIL blink_sec k=%0d: an=%b seg=%b expected %b %b",
                 k_v[i], an, seg, an_v[i], seg_v[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    apply_reset(7'd120, 6'd7, 1'b0, 1'b0);
    tick_to(25);
    checks++;
    if (an !== 4'b1011 || seg !== 7'b0111111 || dp !== 1'b0) begin
      errors++; $display("FAIL oor_min_units: an=%b seg=%b dp=%b expected 1011 0111111 0", an, seg, dp);
    end
    tick_to(35);
    checks++;
    if (an !== 4'b0111 || seg !== 7'b0111111) begin
      errors++; $display("FAIL oor_min_tens: an=%b seg=%b expected 0111 0111111", an, seg);
    end
    tick_to(45);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1111000) begin
      errors++; $display("FAIL oor_sec_ok: an=%b seg=%b expected 1110 1111000", an, seg);
    end
    apply_reset(7'd42, 6'd60, 1'b0, 1'b0);
    tick_to(5);
    checks++;
    if (seg !== 7'b0111111) begin
      errors++; $display("FAIL oor_sec_units: seg=%b expected 0111111", seg);
    end
    tick_to(15);
    checks++;
    if (seg !== 7'b0111111) begin
      errors++; $display("FAIL oor_sec_tens: seg=%b expected 0111111", seg);
    end
    tick_to(25);
    checks++;
    if (seg !== 7'b0100100) begin
      errors++; $display("FAIL oor_sec_min_ok: seg=%b expected 0100100", seg);
    end
  endtask

  task automatic test_glitch_and_reset();
    int shown3 = 0;
    int shown2 = 0;
    apply_reset(7'd42, 6'd7, 1'b0, 1'b0);
    tick_to(50);
    minutes = 7'd43;
    tick();
    minutes = 7'd42;
    while (kcnt < 90) begin
      tick();
      if (an == 4'b1011 && seg == 7'b0110000) shown3++;
      if (an == 4'b1011 && seg == 7'b0100100) shown2++;
    end
    checks++;
    if (shown3 !== 0) begin
      errors++; $display("FAIL glitch_hidden: cycles=%0d expected 0", shown3);
    end
    checks++;
    if (shown2 !== 10) begin
      errors++; $display("FAIL glitch_old_value: cycles=%0d expected 10", shown2);
    end
    minutes = 7'd43;
    tick_to(105);
    checks++;
    if (an !== 4'b1011 || seg !== 7'b0110000 || dp !== 1'b0) begin
      errors++; $display("FAIL stable_update: an=%b seg=%b dp=%b expected 1011 0110000 0", an, seg, dp);
    end
    tick_to(107);
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      errors++; $display("FAIL midscan_reset: an=%b seg=%b dp=%b expected 1111 1111111 1", an, seg, dp);
    end
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    kcnt = 0;
    tick();
    checks++;
    if (an !== 4'b1110) begin
      errors++; $display("FAIL after_midscan_reset: an=%b expected 1110", an);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_blink_minutes();
    test_blink_seconds();
    test_out_of_range();
    test_glitch_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
